// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register family (SIPO now, PISO and
// universal variants later). Direction constants and the completion-stage
// action type live here so every variant agrees on their meaning.
package shift_reg_pkg;

   // Direction select for the shift cores.
   // MSB first: the first bit received ends up in bit WIDTH-1 (left shift).
   // LSB first: the first bit received ends up in bit 0 (right shift).
   localparam bit SHIFT_MSB_FIRST = 1'b1;
   localparam bit SHIFT_LSB_FIRST = 1'b0;

   // What the word holding stage does on a given clock edge.
   //   HOLD_IDLE    : nothing changes
   //   HOLD_ACCEPT  : a freshly completed word is loaded, valid goes high
   //   HOLD_DROP    : a word completed but the holding register is still
   //                  occupied and not being consumed, so the word is lost
   //   HOLD_CONSUME : the consumer takes the held word, valid goes low
   typedef enum logic [1:0] {
      HOLD_IDLE    = 2'd0,
      HOLD_ACCEPT  = 2'd1,
      HOLD_DROP    = 2'd2,
      HOLD_CONSUME = 2'd3
   } hold_action_e;

endpackage

// File: rtl/shift_core.sv
// Parametrised shift register with enable, synchronous clear and a
// compile-time shift direction. Besides the registered contents it exposes
// the value the register would take on an enabled shift, so a parent block
// can capture a completed word on the very edge it is formed.
import shift_reg_pkg::*;

module shift_core #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = SHIFT_MSB_FIRST
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] shift_next
);

   // Next contents after one shift, in the direction chosen at build time.
   // Left shift pushes the new bit in at bit 0 so the oldest bit walks up
   // towards the MSB; right shift does the mirror image.
   always_comb begin
      shift_next = data;
      if (MSB_FIRST == SHIFT_MSB_FIRST) begin
         shift_next = {data[WIDTH-2:0], serial_in};
      end else begin
         shift_next = {serial_in, data[WIDTH-1:1]};
      end
   end

   // Register update: clear beats shift, and without an enable the
   // contents hold indefinitely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= '0;
      end else if (clear) begin
         data <= '0;
      end else if (shift_en) begin
         data <= shift_next;
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer. A shift_core collects bits; a bit
// counter frames them into WIDTH-bit words; each completed word is handed
// to a valid/ready holding stage. A word that completes while the holding
// register is still occupied (and not being taken on that edge) is dropped
// and flagged through the sticky overrun output.
import shift_reg_pkg::*;

module sipo_deserializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = SHIFT_MSB_FIRST
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     serial_in,
   input  logic                     shift_en,
   output logic [WIDTH-1:0]         parallel_out,
   output logic [$clog2(WIDTH)-1:0] bit_count,
   output logic [WIDTH-1:0]         word_out,
   output logic                     word_valid,
   input  logic                     word_ready,
   output logic                     overrun
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr_data;
   logic [WIDTH-1:0] sr_next;
   logic [CW-1:0]    count_q;
   logic             do_shift;
   logic             word_done;
   logic             consume;
   hold_action_e     hold_action;

   shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift_core (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .shift_en   (shift_en),
      .serial_in  (serial_in),
      .data       (sr_data),
      .shift_next (sr_next)
   );

   assign parallel_out = sr_data;
   assign bit_count    = count_q;

   // Edge qualifiers: a shift only happens when clear is not overriding it,
   // the word completes on the shift that carries the last bit, and the
   // consumer only takes a word that is actually being presented.
   always_comb begin
      do_shift  = shift_en && !clear;
      word_done = do_shift && (count_q == LAST_BIT);
      consume   = word_valid && word_ready;
   end

   // Bit counter: advances on every shift and wraps to zero when the word
   // completes. The shift register itself is deliberately not cleared at
   // completion, so parallel_out keeps showing the last word until new bits
   // push it out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (shift_en) begin
         if (count_q == LAST_BIT) begin
            count_q <= '0;
         end else begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   // Decide what the holding stage does this edge. A completing word may
   // take the slot if it is empty or being emptied on this same edge;
   // otherwise the new word is lost. Consumption alone just frees the slot.
   always_comb begin
      hold_action = HOLD_IDLE;
      if (word_done) begin
         if (!word_valid || consume) begin
            hold_action = HOLD_ACCEPT;
         end else begin
            hold_action = HOLD_DROP;
         end
      end else if (consume) begin
         hold_action = HOLD_CONSUME;
      end
   end

   // Holding register. clear does not touch it: a word already framed is
   // still deliverable after the partial word is aborted. The word captured
   // is the post-shift value, so word_out equals parallel_out right after a
   // completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_out   <= '0;
         word_valid <= 1'b0;
      end else begin
         unique case (hold_action)
            HOLD_ACCEPT: begin
               word_out   <= sr_next;
               word_valid <= 1'b1;
            end
            HOLD_CONSUME: begin
               word_valid <= 1'b0;
            end
            HOLD_DROP: begin
               word_valid <= 1'b1;
            end
            HOLD_IDLE: begin
               word_valid <= word_valid;
            end
         endcase
      end
   end

   // Sticky overrun flag: set by any dropped word and only cleared by reset
   // or by an explicit clear, so software/consumers can see that data was
   // lost at some point since the last abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (clear) begin
         overrun <= 1'b0;
      end else if (hold_action == HOLD_DROP) begin
         overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Testbench for sipo_deserializer. Two 4-bit instances (MSB-first and
// LSB-first) share one set of inputs. A word-level model of each lane is
// compared against the DUTs on every falling edge, and directed scenarios
// add literal expectations that pin the model itself.
module tb_sipo_deserializer;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;
   logic clear;
   logic serial_in;
   logic shift_en;
   logic word_ready;

   logic [W-1:0] po_m, wo_m, po_l, wo_l;
   logic [1:0]   bc_m, bc_l;
   logic         wv_m, ov_m, wv_l, ov_l;

   int tests_run    = 0;
   int tests_failed = 0;
   bit compare_on   = 1'b0;

   // Lane 0 = MSB first, lane 1 = LSB first.
   int m_sr    [2];
   int m_cnt   [2];
   int m_word  [2];
   bit m_valid [2];
   bit m_ovr   [2];

   always #5 clk = ~clk;

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .serial_in    (serial_in),
      .shift_en     (shift_en),
      .parallel_out (po_m),
      .bit_count    (bc_m),
      .word_out     (wo_m),
      .word_valid   (wv_m),
      .word_ready   (word_ready),
      .overrun      (ov_m)
   );

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .serial_in    (serial_in),
      .shift_en     (shift_en),
      .parallel_out (po_l),
      .bit_count    (bc_l),
      .word_out     (wo_l),
      .word_valid   (wv_l),
      .word_ready   (word_ready),
      .overrun      (ov_l)
   );

   // Word-level model: the register is an integer shifted arithmetically,
   // the count is taken modulo W, and the holding stage follows the
   // accept/drop/consume rules.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_sr[i] = 0; m_cnt[i] = 0; m_word[i] = 0;
            m_valid[i] = 1'b0; m_ovr[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit taken;
            taken = m_valid[i] && (word_ready === 1'b1);
            if (clear) begin
               m_sr[i] = 0; m_cnt[i] = 0; m_ovr[i] = 1'b0;
               if (taken) m_valid[i] = 1'b0;
            end else if (shift_en) begin
               if (i == 0) m_sr[i] = ((m_sr[i] * 2) + int'(serial_in)) % (1 << W);
               else        m_sr[i] = (m_sr[i] / 2) + int'(serial_in) * (1 << (W - 1));
               m_cnt[i] = m_cnt[i] + 1;
               if (m_cnt[i] == W) begin
                  m_cnt[i] = 0;
                  if (!m_valid[i] || taken) begin
                     m_word[i] = m_sr[i]; m_valid[i] = 1'b1;
                  end else begin
                     m_ovr[i] = 1'b1;
                  end
               end else if (taken) begin
                  m_valid[i] = 1'b0;
               end
            end else if (taken) begin
               m_valid[i] = 1'b0;
            end
         end
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Continuous comparison against the model on every falling edge.
   always @(negedge clk) begin
      if (compare_on) begin
         check_output("model msb parallel_out", 32'(po_m), m_sr[0]);
         check_output("model msb bit_count",    32'(bc_m), m_cnt[0]);
         check_output("model msb word_out",     32'(wo_m), m_word[0]);
         check_output("model msb word_valid",   32'(wv_m), 32'(m_valid[0]));
         check_output("model msb overrun",      32'(ov_m), 32'(m_ovr[0]));
         check_output("model lsb parallel_out", 32'(po_l), m_sr[1]);
         check_output("model lsb bit_count",    32'(bc_l), m_cnt[1]);
         check_output("model lsb word_out",     32'(wo_l), m_word[1]);
         check_output("model lsb word_valid",   32'(wv_l), 32'(m_valid[1]));
         check_output("model lsb overrun",      32'(ov_l), 32'(m_ovr[1]));
      end
   end

   task automatic apply_stimulus(input logic c, input logic se, input logic si,
                                 input logic rdy);
      @(negedge clk);
      clear      = c;
      shift_en   = se;
      serial_in  = si;
      word_ready = rdy;
   endtask

   // Sends bits[3] first; word_ready is raised only with the last bit.
   task automatic shift_word(input logic [3:0] bits, input logic rdy_last);
      for (int i = 3; i >= 0; i--) begin
         apply_stimulus(1'b0, 1'b1, bits[i], (i == 0) ? rdy_last : 1'b0);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic consume_word();
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_both(input string tag, input logic [3:0] exp_m,
                             input logic [3:0] exp_l, input logic exp_v,
                             input logic exp_o);
      check_output({tag, " msb word_out"},   32'(wo_m), 32'(exp_m));
      check_output({tag, " lsb word_out"},   32'(wo_l), 32'(exp_l));
      check_output({tag, " msb word_valid"}, 32'(wv_m), 32'(exp_v));
      check_output({tag, " lsb word_valid"}, 32'(wv_l), 32'(exp_v));
      check_output({tag, " msb overrun"},    32'(ov_m), 32'(exp_o));
      check_output({tag, " lsb overrun"},    32'(ov_l), 32'(exp_o));
   endtask

   logic [3:0] burst_words [4] = '{4'hA, 4'h5, 4'hF, 4'h3};
   logic       burst_ready [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      rst = 1'b1; clear = 1'b0; serial_in = 1'b0; shift_en = 1'b0; word_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      compare_on = 1'b1;

      // Reset state.
      #1;
      check_both("reset", 4'h0, 4'h0, 1'b0, 1'b0);
      check_output("reset msb parallel_out", 32'(po_m), 32'h0);
      check_output("reset msb bit_count",    32'(bc_m), 32'h0);

      // Back-to-back stream 1,0,1,1.
      shift_word(4'b1011, 1'b0);
      settle();
      check_output("stream msb parallel_out", 32'(po_m), 32'b1011);
      check_output("stream msb bit_count",    32'(bc_m), 32'h0);
      check_both("stream", 4'b1011, 4'b1101, 1'b1, 1'b0);
      consume_word();
      check_both("consume", 4'b1011, 4'b1101, 1'b0, 1'b0);

      // Same stream with 3 idle cycles between bits.
      for (int i = 3; i >= 0; i--) begin
         apply_stimulus(1'b0, 1'b1, (i == 0 || i == 1 || i == 3), 1'b0);
         if (i != 0) repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
         if (i == 3) begin
            check_output("gap msb bit_count hold", 32'(bc_m), 32'd1);
            check_output("gap lsb bit_count hold", 32'(bc_l), 32'd1);
         end
      end
      settle();
      check_output("gap msb bit_count", 32'(bc_m), 32'h0);
      check_both("gap", 4'b1011, 4'b1101, 1'b1, 1'b0);
      consume_word();

      // Overrun: two words with no consumer, then clear.
      shift_word(4'b1011, 1'b0);
      shift_word(4'b0110, 1'b0);
      settle();
      check_both("overrun", 4'b1011, 4'b1101, 1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      settle();
      check_both("clear ovr", 4'b1011, 4'b1101, 1'b1, 1'b0);
      check_output("clear msb parallel_out", 32'(po_m), 32'h0);

      // Ready on exactly the completion edge while a word is held.
      shift_word(4'b0110, 1'b1);
      settle();
      check_both("replace", 4'b0110, 4'b0110, 1'b1, 1'b0);
      consume_word();

      // Partial word aborted by clear.
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      settle();
      check_output("abort msb word_valid", 32'(wv_m), 32'h0);
      check_output("abort msb bit_count",  32'(bc_m), 32'h0);
      shift_word(4'b0010, 1'b0);
      settle();
      check_both("abort", 4'b0010, 4'b0100, 1'b1, 1'b0);
      consume_word();

      // Asynchronous reset mid-word, then a full word.
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_both("async rst", 4'h0, 4'h0, 1'b0, 1'b0);
      check_output("async rst msb parallel_out", 32'(po_m), 32'h0);
      check_output("async rst lsb bit_count",    32'(bc_l), 32'h0);
      @(negedge clk);
      rst = 1'b0; shift_en = 1'b0;
      shift_word(4'b1001, 1'b0);
      settle();
      check_both("post rst", 4'b1001, 4'b1001, 1'b1, 1'b0);

      // Back-to-back words with mixed readiness, checked by the model.
      for (int k = 0; k < 4; k++) begin
         shift_word(burst_words[k], burst_ready[k]);
      end
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);

      compare_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
